uart_tx_frame_ctrl: RTL and testbench

Frame controller and serializer for the UART transmitter, sitting directly upstream of the 4:1 TX output mux. It accepts a parallel byte, computes parity and walks the frame through start, data, optional parity and stop. Each cycle it drives the mux select, the current serial data bit and the parity bit. One bit is produced per clock, so CLK is the bit-rate clock.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_parity_calc.sv | 13 +
 rtl/uart_tx_frame_ctrl.sv | 107 ++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit path: mux selects,
// frame controller states and parity types.
package uart_tx_pkg;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity of a payload word; par_typ_i=1 inverts the even
// parity so the frame carries an odd number of ones.
module uart_tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  assign par_bit_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: latches a byte, then walks
// start, data (LSB first), optional parity and stop bits.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [SEL_WIDTH-1:0]  MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
  logic                  par_calc;
  logic [1:0]            sel;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .data_i   (P_DATA),
    .par_typ_i(PAR_TYP),
    .par_bit_o(par_calc)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pen_d   = pen_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Data_Valid) begin
          shift_d = P_DATA;
          pen_d   = PAR_EN;
          par_d   = par_calc;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = pen_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
    end
  end

  // Outputs come from flops only, so no input reaches them
  always_comb begin
    sel = SEL_STOP;
    case (state_q)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PARITY;
      default:   sel = SEL_STOP;
    endcase
  end

  assign MUX_SEL  = SEL_WIDTH'(sel);
  assign Busy     = (state_q != ST_IDLE);
  assign SER_DATA = shift_q[0];
  assign PAR_BIT  = par_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: reset, 8N1,
// parity modes, held Data_Valid and mid-frame reset.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [1:0]    MUX_SEL;
  logic          SER_DATA;
  logic          PAR_BIT;
  logic          Busy;

  int tests = 0;
  int fails = 0;

  logic [1:0] cap_mux [0:31];
  logic       cap_ser [0:31];
  logic       cap_par [0:31];
  int         cap_len;
  int         cap_pre;
  logic [1:0] tail_mux;
  logic       tail_busy;

  uart_tx_frame_ctrl #(
    .DATA_WIDTH(DW),
    .SEL_WIDTH (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .MUX_SEL   (MUX_SEL),
    .SER_DATA  (SER_DATA),
    .PAR_BIT   (PAR_BIT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] exp_mux(int i, logic pen);
    if (i == 0) return 2'b00;
    if (i <= DW) return 2'b10;
    if (pen && i == DW + 1) return 2'b11;
    return 2'b01;
  endfunction

  // Records one frame at negedges; bounded on both waits
  task automatic capture();
    cap_len = 0;
    cap_pre = 0;
    @(negedge CLK);
    while (Busy !== 1'b1 && cap_pre < 20) begin
      cap_pre++;
      @(negedge CLK);
    end
    while (Busy === 1'b1 && cap_len < 32) begin
      cap_mux[cap_len] = MUX_SEL;
      cap_ser[cap_len] = SER_DATA;
      cap_par[cap_len] = PAR_BIT;
      cap_len++;
      @(negedge CLK);
    end
    tail_mux  = MUX_SEL;
    tail_busy = Busy;
  endtask

  task automatic send(input logic [DW-1:0] d,
                      input logic pen, input logic pt);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      tests++;
      if (MUX_SEL !== 2'b01 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_cyc%0d mux=%b busy=%b want 01/0",
                 c, MUX_SEL, Busy);
      end
      tests++;
      if (SER_DATA !== 1'b0 || PAR_BIT !== 1'b0) begin
        fails++;
        $display("FAIL reset_out%0d ser=%b par=%b want 0/0",
                 c, SER_DATA, PAR_BIT);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    Data_Valid = 1'b0;
    tests++;
    if (MUX_SEL !== 2'b00 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_release mux=%b busy=%b want 00/1",
               MUX_SEL, Busy);
    end
    capture();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_8n1();
    logic [DW-1:0] d;
    d = 8'hA5;
    send(d, 1'b0, 1'b0);
    capture();
    tests++;
    if (cap_len !== 10 || cap_pre !== 0) begin
      fails++;
      $display("FAIL 8n1_len got %0d pre %0d want 10 pre 0",
               cap_len, cap_pre);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap_mux[i] !== exp_mux(i, 1'b0)) begin
        fails++;
        $display("FAIL 8n1_mux[%0d] got %b want %b",
                 i, cap_mux[i], exp_mux(i, 1'b0));
      end
    end
    for (int i = 1; i <= DW; i++) begin
      tests++;
      if (cap_ser[i] !== d[i-1]) begin
        fails++;
        $display("FAIL 8n1_ser[%0d] got %b want %b",
                 i - 1, cap_ser[i], d[i-1]);
      end
    end
    tests++;
    if (tail_mux !== 2'b01 || tail_busy !== 1'b0) begin
      fails++;
      $display("FAIL 8n1_tail mux=%b busy=%b want 01/0",
               tail_mux, tail_busy);
    end
    @(posedge CLK);
    #1;
  endtask

  // Runs one parity frame and checks length, selects, data, parity
  task automatic test_parity(input logic [DW-1:0] d,
                             input logic pt,
                             input logic ep,
                             input string nm);
    send(d, 1'b1, pt);
    capture();
    tests++;
    if (cap_len !== 11) begin
      fails++;
      $display("FAIL %s_len got %0d want 11", nm, cap_len);
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (cap_mux[i] !== exp_mux(i, 1'b1)) begin
        fails++;
        $display("FAIL %s_mux[%0d] got %b want %b",
                 nm, i, cap_mux[i], exp_mux(i, 1'b1));
      end
      tests++;
      if (cap_par[i] !== ep) begin
        fails++;
        $display("FAIL %s_par[%0d] got %b want %b",
                 nm, i, cap_par[i], ep);
      end
    end
    for (int i = 1; i <= DW; i++) begin
      tests++;
      if (cap_ser[i] !== d[i-1]) begin
        fails++;
        $display("FAIL %s_ser[%0d] got %b want %b",
                 nm, i - 1, cap_ser[i], d[i-1]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    d1 = 8'hA5;
    d2 = 8'h3C;
    P_DATA     = d1;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA  = d2;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b1;
    capture();
    tests++;
    if (cap_len !== 10) begin
      fails++;
      $display("FAIL b2b_f1_len got %0d want 10", cap_len);
    end
    for (int i = 1; i <= DW; i++) begin
      tests++;
      if (cap_ser[i] !== d1[i-1]) begin
        fails++;
        $display("FAIL b2b_f1_ser[%0d] got %b want %b",
                 i - 1, cap_ser[i], d1[i-1]);
      end
    end
    tests++;
    if (tail_mux !== 2'b01 || tail_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle mux=%b busy=%b want 01/0",
               tail_mux, tail_busy);
    end
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
    capture();
    tests++;
    if (cap_pre !== 0 || cap_len !== 11) begin
      fails++;
      $display("FAIL b2b_f2 pre %0d len %0d want 0 and 11",
               cap_pre, cap_len);
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (cap_mux[i] !== exp_mux(i, 1'b1)) begin
        fails++;
        $display("FAIL b2b_f2_mux[%0d] got %b want %b",
                 i, cap_mux[i], exp_mux(i, 1'b1));
      end
    end
    for (int i = 1; i <= DW; i++) begin
      tests++;
      if (cap_ser[i] !== d2[i-1]) begin
        fails++;
        $display("FAIL b2b_f2_ser[%0d] got %b want %b",
                 i - 1, cap_ser[i], d2[i-1]);
      end
    end
    tests++;
    if (cap_par[0] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_f2_par got %b want 1", cap_par[0]);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    d = 8'h3C;
    send(8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(negedge CLK);
    tests++;
    if (MUX_SEL !== 2'b10 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_data4 mux=%b busy=%b want 10/1",
               MUX_SEL, Busy);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      tests++;
      if (MUX_SEL !== 2'b01 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL midrst_idle%0d mux=%b busy=%b want 01/0",
                 c, MUX_SEL, Busy);
      end
    end
    tests++;
    if (SER_DATA !== 1'b0 || PAR_BIT !== 1'b0) begin
      fails++;
      $display("FAIL midrst_out ser=%b par=%b want 0/0",
               SER_DATA, PAR_BIT);
    end
    @(posedge CLK);
    #1;
    send(d, 1'b1, 1'b0);
    capture();
    tests++;
    if (cap_len !== 11 || cap_pre !== 0) begin
      fails++;
      $display("FAIL midrst_len got %0d pre %0d want 11 pre 0",
               cap_len, cap_pre);
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (cap_mux[i] !== exp_mux(i, 1'b1)) begin
        fails++;
        $display("FAIL midrst_mux[%0d] got %b want %b",
                 i, cap_mux[i], exp_mux(i, 1'b1));
      end
    end
    for (int i = 1; i <= DW; i++) begin
      tests++;
      if (cap_ser[i] !== d[i-1]) begin
        fails++;
        $display("FAIL midrst_ser[%0d] got %b want %b",
                 i - 1, cap_ser[i], d[i-1]);
      end
    end
    tests++;
    if (cap_par[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_par got %b want 0", cap_par[0]);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity(8'hA5, 1'b0, 1'b0, "even_a5");
    test_parity(8'h07, 1'b0, 1'b1, "even_07");
    test_parity(8'hA5, 1'b1, 1'b1, "odd_a5");
    test_parity(8'h00, 1'b1, 1'b1, "odd_00");
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
